ntt_stage_scheduler: RTL and testbench
======================================

// Module: ntt_stage_scheduler
// PURPOSE
//  Parametrised stage sequencer for the multi-bank NTT/INTT core: replaces hard-wired fsm + fixed shifters.
//  Per cycle, issues BANKS logical coefficient indices (BANKS/2 radix-2 butterflies) plus twiddle indices.
//  Replays the same indices as write addresses after a mode-selected latency.
//  Drains the pipeline between stages (RAW-safe) and provides a start/busy/done handshake with stall.
//  Sits between the top-level controller and the conflict-free memory map / tf ROM address path.
// PARAMETERS
//  LOG_N     9   log2 transform length (N=512)
//  LOG_BANKS 2   log2 lanes per cycle (BANKS=4); 1 <= LOG_BANKS < LOG_N
//  LAT_NTT   7   read-issue to write-issue latency, NTT mode (1..MAX_LAT)
//  LAT_INTT  13  read-issue to write-issue latency, INTT mode (1..MAX_LAT)
//  MAX_LAT   16  physical delay-line depth
// PORTS
//  clk      in  1               clock, all logic rising-edge
//  rst      in  1               synchronous active-high reset
//  start    in  1               begin transform; sampled only in IDLE
//  mode     in  1               0=NTT (CT, t=LOG_N-1-s), 1=INTT (GS, t=s); latched at start
//  hold     in  1               stall: freezes all state incl. delay line (datapath uses same enable)
//  busy     out 1               high from cycle after accepted start until done
//  done     out 1               one-cycle pulse, transform complete
//  stage    out 4               current stage s, 0..LOG_N-1
//  rd_valid out 1               rd_addr/tf_idx valid this cycle
//  rd_addr  out BANKS*LOG_N     lane k at [k*LOG_N +: LOG_N]
//  tf_idx   out (BANKS/2)*LOG_N twiddle index per butterfly m
//  wr_valid out 1               wr_addr valid this cycle
//  wr_addr  out BANKS*LOG_N     rd_addr delayed by latched latency
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, delay-line valid bits cleared.
//  Reset mid-operation: same; no done pulse; outstanding writes discarded.
//  States:
//   IDLE  -(start)-> READ; cnt=0, s=0, mode latched.
//   READ  -(cnt==N/BANKS-1 & !hold)-> DRAIN.
//   DRAIN lasts exactly LAT cycles (excluding hold cycles);
//         then -> READ with s+1, or -> DONE if s==LOG_N-1.
//   DONE  lasts one cycle (done=1, busy=0), then -> IDLE.
//  Timing: start accepted at cycle 0 -> first rd_valid at cycle 1.
//   Each READ cycle issues one group; cnt increments per issued group.
//   Read issued at cycle t -> matching wr_valid/wr_addr at t+LAT.
//   Next stage's first read = cycle after the previous stage's last write.
//  Address math per lane group: b = cnt*BANKS/2 + m, m=0..BANKS/2-1; d = 1<<t.
//   upper = ((b>>t)<<(t+1)) | (b & (d-1)); lower = upper + d.
//   lane 2m = upper, lane 2m+1 = lower.
//   tf_idx[m] = (1<<(LOG_N-1-t)) + (b>>t); always < N, no overflow.
//  hold=1: no rd_valid, cnt/state/delay line frozen, wr_valid=0.
//   Frozen entries re-emerge unchanged after release.
//  Edge cases:
//   start while busy or in DONE -> ignored.
//   start and hold together in IDLE -> accepted.
//   hold in DONE -> no effect (done still single pulse).
//   stage holds last value while in DRAIN/DONE; returns to 0 in IDLE.
// STRUCTURE
//  Include file ntt_sched_defs.vh: state encodings (IDLE/READ/DRAIN/DONE), MODE_NTT/MODE_INTT constants.
//  Sub-module sched_delay_line (MAX_LAT deep, runtime tap select, valid bit, enable=!hold).
//   Used once for wr path (addr+valid).
//  Address/tf arithmetic is combinational from registered cnt/s/mode; rd outputs are registered.
// TESTING  (defaults: N=512, BANKS=4, 128 groups/stage)
//  NTT run, start@0:
//   stage0 cnt0 -> rd_addr {0,256,1,257}, tf_idx {1,1};
//   wr of same at cycle 8; stage1 first read at cycle 136;
//   stage8 cnt0 -> {0,1,2,3}, tf_idx {256,257};
//   done pulse at cycle 1216.
//  INTT run: stage0 cnt0 -> {0,1,2,3}; stage8 -> {0,256,1,257}; per-stage 141 cycles; done at 1270.
//  hold 5 cycles mid-READ stage3 -> no rd/wr_valid during hold;
//   address sequence unchanged; done 5 cycles late.
//  rst asserted at cycle 600 -> next cycle busy=0, rd_valid=0, wr_valid=0; no done;
//   fresh start then completes normally.
//  start pulsed at cycle 50 while busy -> ignored; exactly one done.
//  Scoreboard: every index 0..N-1 read exactly once and written exactly once per stage;
//   no read of an index before its prior-stage write.

Source files
------------

// File: rtl/ntt_stage_scheduler_pkg.sv
// ntt_stage_scheduler_pkg
//   Shared types and constants for the NTT/INTT stage scheduler: the
//   sequencer state encoding and the mode constants that are latched at start.
//   No ports (package).
package ntt_stage_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam logic MODE_NTT  = 1'b0;  // Cooley-Tukey, t = LOG_N-1-s
  localparam logic MODE_INTT = 1'b1;  // Gentleman-Sande, t = s

endpackage

// File: rtl/ntt_stage_scheduler_if.sv
// ntt_stage_scheduler_if
//   Controller <-> scheduler bundle. The master (top-level controller) drives
//   start/mode/hold; the slave (scheduler) returns handshake status plus the
//   per-cycle read, twiddle and write index groups.
//   start, mode, hold          : controller -> scheduler
//   busy, done, stage          : status
//   rd_valid, rd_addr, tf_idx  : read group (lane k at [k*LOG_N +: LOG_N])
//   wr_valid, wr_addr          : write group, read group replayed after latency
interface ntt_stage_scheduler_if #(
  parameter int LOG_N     = 9,
  parameter int LOG_BANKS = 2
);
  localparam int BANKS = 1 << LOG_BANKS;

  logic                           start;
  logic                           mode;
  logic                           hold;
  logic                           busy;
  logic                           done;
  logic [3:0]                     stage;
  logic                           rd_valid;
  logic [BANKS*LOG_N-1:0]         rd_addr;
  logic [(BANKS/2)*LOG_N-1:0]     tf_idx;
  logic                           wr_valid;
  logic [BANKS*LOG_N-1:0]         wr_addr;

  modport master (
    output start, mode, hold,
    input  busy, done, stage, rd_valid, rd_addr, tf_idx, wr_valid, wr_addr
  );

  modport slave (
    input  start, mode, hold,
    output busy, done, stage, rd_valid, rd_addr, tf_idx, wr_valid, wr_addr
  );
endinterface

// File: rtl/sched_delay_line.sv
// sched_delay_line
//   Fixed-depth shift register carrying a valid bit plus payload, read at a
//   runtime-selected tap. A word entering at cycle t appears on the outputs
//   at cycle t+tap+1. When en is low nothing shifts and out_valid is forced
//   low, so stalled entries re-emerge unchanged once en returns.
//   clk, rst            : clock, synchronous active-high reset (clears all)
//   en                  : shift enable (datapath stall = !en)
//   tap                 : output stage select, 0..DEPTH-1
//   in_valid, in_data   : word entering this cycle
//   out_valid, out_data : word at the selected tap
module sched_delay_line #(
  parameter int W     = 36,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] tap,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  output logic [W-1:0]             out_data
);

  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [DEPTH-1:0][W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (en) begin
      vld_d = {vld_q[DEPTH-2:0], in_valid};
      dat_d = {dat_q[DEPTH-2:0], in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[tap] & en;
  assign out_data  = dat_q[tap];

endmodule

// File: rtl/ntt_stage_scheduler.sv
// ntt_stage_scheduler
//   Stage sequencer for the multi-bank NTT/INTT core. Each READ cycle issues
//   BANKS coefficient indices (BANKS/2 radix-2 butterflies) and their twiddle
//   indices; the same indices are replayed as write addresses after the
//   mode-selected latency. Between stages the pipeline is drained so the next
//   stage never reads a coefficient before its previous-stage write.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of ntt_stage_scheduler_if (start/mode/hold in;
//              busy/done/stage, rd_valid/rd_addr/tf_idx, wr_valid/wr_addr out)
module ntt_stage_scheduler #(
  parameter int LOG_N     = 9,
  parameter int LOG_BANKS = 2,
  parameter int LAT_NTT   = 7,
  parameter int LAT_INTT  = 13,
  parameter int MAX_LAT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ntt_stage_scheduler_if.slave  bus
);
  import ntt_stage_scheduler_pkg::*;

  localparam int BANKS  = 1 << LOG_BANKS;
  localparam int HB     = BANKS / 2;
  localparam int GROUPS = 1 << (LOG_N - LOG_BANKS);
  localparam int CW     = LOG_N - LOG_BANKS;
  localparam int SW     = $clog2(LOG_N);
  localparam int DW     = $clog2(MAX_LAT + 1);
  localparam int TW     = $clog2(MAX_LAT);
  localparam int AW     = BANKS * LOG_N;

  sched_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] s_q, s_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic [DW-1:0] lat_m1;
  logic          rd_valid;
  logic [SW-1:0] t, tf_sh;

  logic [BANKS-1:0][LOG_N-1:0] rd_lanes;
  logic [HB-1:0][LOG_N-1:0]    tf_lanes;
  logic                        wr_valid;
  logic [AW-1:0]               wr_data;

  assign lat_m1   = (mode_q == MODE_INTT) ? DW'(LAT_INTT - 1) : DW'(LAT_NTT - 1);
  assign rd_valid = (state_q == ST_READ) && !bus.hold;

  // ---------------- sequencer ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    mode_d  = mode_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // hold is deliberately ignored here: start+hold is still accepted
        if (bus.start) begin
          state_d = ST_READ;
          cnt_d   = '0;
          s_d     = '0;
          mode_d  = bus.mode;
        end
      end
      ST_READ: begin
        if (!bus.hold) begin
          if (cnt_q == CW'(GROUPS - 1)) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
            dcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // LAT unstalled cycles: the last write of this stage lands in the
        // final DRAIN cycle, so the next stage's first read follows it.
        if (!bus.hold) begin
          if (dcnt_q == lat_m1) begin
            if (s_q == SW'(LOG_N - 1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_READ;
              s_d     = s_q + 1'b1;
            end
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        s_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      mode_q  <= MODE_NTT;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      mode_q  <= mode_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // ---------------- address / twiddle math ----------------
  // t is the butterfly span exponent; tf_sh = LOG_N-1-t picks the twiddle
  // table level so tf_idx = 2^(LOG_N-1-t) + (b>>t) stays below N.
  assign t     = (mode_q == MODE_INTT) ? s_q : SW'(LOG_N - 1) - s_q;
  assign tf_sh = SW'(LOG_N - 1) - t;

  for (genvar m = 0; m < HB; m++) begin : g_bfly
    logic [LOG_N-1:0] b, d, hi, up, lo, tf;
    always_comb begin
      b  = (LOG_N'(cnt_q) << (LOG_BANKS - 1)) | LOG_N'(m);
      d  = LOG_N'(1) << t;
      hi = b >> t;
      // insert a zero at bit t: upper partner of the butterfly
      up = ((hi << t) << 1) | (b & (d - LOG_N'(1)));
      lo = up + d;
      tf = (LOG_N'(1) << tf_sh) + hi;
    end
    assign rd_lanes[2*m]   = up;
    assign rd_lanes[2*m+1] = lo;
    assign tf_lanes[m]     = tf;
  end

  // ---------------- write replay ----------------
  sched_delay_line #(
    .W     (AW),
    .DEPTH (MAX_LAT)
  ) u_wr_dly (
    .clk       (clk),
    .rst       (rst),
    .en        (!bus.hold),
    .tap       (lat_m1[TW-1:0]),
    .in_valid  (rd_valid),
    .in_data   (rd_lanes),
    .out_valid (wr_valid),
    .out_data  (wr_data)
  );

  // ---------------- outputs ----------------
  assign bus.busy     = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.stage    = 4'(s_q);
  assign bus.rd_valid = rd_valid;
  assign bus.rd_addr  = rd_valid ? rd_lanes : '0;
  assign bus.tf_idx   = rd_valid ? tf_lanes : '0;
  assign bus.wr_valid = wr_valid;
  assign bus.wr_addr  = wr_valid ? wr_data : '0;

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
module tb_ntt_stage_scheduler;
  localparam int LOG_N = 9;
  localparam int NST   = 9;
  localparam int NGRP  = 128;
  localparam int NRD   = NST * NGRP;
  localparam int NIDX  = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ntt_stage_scheduler_if #(.LOG_N(LOG_N), .LOG_BANKS(2)) bus();

  ntt_stage_scheduler #(
    .LOG_N(LOG_N), .LOG_BANKS(2), .LAT_NTT(7), .LAT_INTT(13), .MAX_LAT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc, rst_at, extra_start, h0_from, h0_len, h1_from, h1_len;
  int rd_n, wr_n, done_n, done_cyc, hold_bad, raw_bad, busy_at_done;
  int first_rd[NST];
  int first_wr[NST];
  logic [35:0] rd_seq [NRD];
  logic [35:0] wr_seq [NRD];
  logic [35:0] ref_seq[NRD];
  logic [17:0] tf_seq [NRD];
  int rdcnt[NST][NIDX];
  int wrcnt[NST][NIDX];

  task automatic clear_log();
    rst_at = -1; extra_start = -1;
    h0_from = -1; h0_len = 0; h1_from = -1; h1_len = 0;
    rd_n = 0; wr_n = 0; done_n = 0; done_cyc = -1;
    hold_bad = 0; raw_bad = 0; busy_at_done = -1;
    for (int s = 0; s < NST; s++) begin
      first_rd[s] = -1; first_wr[s] = -1;
      for (int i = 0; i < NIDX; i++) begin rdcnt[s][i] = 0; wrcnt[s][i] = 0; end
    end
    for (int i = 0; i < NRD; i++) begin rd_seq[i] = '0; wr_seq[i] = '0; tf_seq[i] = '0; end
  endtask

  function automatic bit in_hold(int c);
    return (c >= h0_from && c < h0_from + h0_len) ||
           (c >= h1_from && c < h1_from + h1_len);
  endfunction

  // bookkeeping only; the test tasks judge the collected data
  task automatic sample();
    int st, idx;
    st = int'(bus.stage);
    if (st >= NST) st = NST - 1;
    if ((bus.rd_valid || bus.wr_valid) && bus.hold) hold_bad++;
    if (bus.rd_valid) begin
      if (rd_n < NRD) begin rd_seq[rd_n] = bus.rd_addr; tf_seq[rd_n] = bus.tf_idx; end
      if (first_rd[st] < 0) first_rd[st] = cyc;
      for (int k = 0; k < 4; k++) begin
        idx = int'(bus.rd_addr[k*LOG_N +: LOG_N]);
        if (st > 0 && wrcnt[st-1][idx] == 0) raw_bad++;
        rdcnt[st][idx]++;
      end
      rd_n++;
    end
    if (bus.wr_valid) begin
      if (wr_n < NRD) wr_seq[wr_n] = bus.wr_addr;
      if (first_wr[st] < 0) first_wr[st] = cyc;
      for (int k = 0; k < 4; k++) begin
        idx = int'(bus.wr_addr[k*LOG_N +: LOG_N]);
        wrcnt[st][idx]++;
      end
      wr_n++;
    end
    if (bus.done) begin
      done_n++;
      if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = int'(bus.busy); end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    bus.start = (cyc == extra_start);
    bus.hold  = in_hold(cyc);
    if (rst_at >= 0) rst = (cyc == rst_at);
    #1;
    sample();
  endtask

  task automatic run(input logic m, input int budget);
    cyc = 0;
    bus.mode  = m;
    bus.start = 1'b1;
    bus.hold  = in_hold(0);
    while (done_cyc < 0 && cyc < budget) step();
    repeat (5) step();
  endtask

  function automatic int cov_bad();
    int n = 0;
    for (int s = 0; s < NST; s++)
      for (int i = 0; i < NIDX; i++)
        if (rdcnt[s][i] != 1 || wrcnt[s][i] != 1) n++;
    return n;
  endfunction

  function automatic int seq_bad();
    int n = 0;
    for (int i = 0; i < NRD; i++) if (wr_seq[i] !== rd_seq[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    clear_log();
    rst = 1'b1; bus.start = 1'b0; bus.hold = 1'b0; bus.mode = 1'b0;
    repeat (3) step();
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++;
      $display("FAIL reset_busy_done busy=%b done=%b want 0 0", bus.busy, bus.done); end
    total++; if (bus.rd_valid !== 1'b0 || bus.wr_valid !== 1'b0) begin bad++;
      $display("FAIL reset_valid rd=%b wr=%b want 0 0", bus.rd_valid, bus.wr_valid); end
    total++; if (bus.stage !== 4'd0 || bus.rd_addr !== '0 || bus.tf_idx !== '0 || bus.wr_addr !== '0) begin bad++;
      $display("FAIL reset_buses stage=%0d rd=%h tf=%h wr=%h want all 0", bus.stage, bus.rd_addr, bus.tf_idx, bus.wr_addr); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ntt();
    logic [35:0] e0, e8;
    logic [17:0] t0, t8;
    e0 = {9'd257, 9'd1, 9'd256, 9'd0}; t0 = {9'd1, 9'd1};
    e8 = {9'd3, 9'd2, 9'd1, 9'd0};     t8 = {9'd257, 9'd256};
    clear_log();
    run(1'b0, 2000);
    total++; if (rd_seq[0] !== e0) begin bad++; $display("FAIL ntt_s0_addr got %h want %h", rd_seq[0], e0); end
    total++; if (tf_seq[0] !== t0) begin bad++; $display("FAIL ntt_s0_tf got %h want %h", tf_seq[0], t0); end
    total++; if (first_rd[0] != 1) begin bad++; $display("FAIL ntt_first_rd got %0d want 1", first_rd[0]); end
    total++; if (first_wr[0] != 8) begin bad++; $display("FAIL ntt_first_wr got %0d want 8", first_wr[0]); end
    total++; if (first_rd[1] != 136) begin bad++; $display("FAIL ntt_s1_start got %0d want 136", first_rd[1]); end
    total++; if (rd_seq[8*NGRP] !== e8) begin bad++; $display("FAIL ntt_s8_addr got %h want %h", rd_seq[8*NGRP], e8); end
    total++; if (tf_seq[8*NGRP] !== t8) begin bad++; $display("FAIL ntt_s8_tf got %h want %h", tf_seq[8*NGRP], t8); end
    total++; if (done_cyc != 1216 || done_n != 1) begin bad++; $display("FAIL ntt_done cyc=%0d n=%0d want 1216 1", done_cyc, done_n); end
    total++; if (busy_at_done != 0) begin bad++; $display("FAIL ntt_busy_at_done got %0d want 0", busy_at_done); end
    total++; if (rd_n != NRD || wr_n != NRD || seq_bad() != 0) begin bad++;
      $display("FAIL ntt_replay rd=%0d wr=%0d seqdiff=%0d want %0d %0d 0", rd_n, wr_n, seq_bad(), NRD, NRD); end
    total++; if (cov_bad() != 0 || raw_bad != 0) begin bad++; $display("FAIL ntt_scoreboard cov=%0d raw=%0d want 0 0", cov_bad(), raw_bad); end
    total++; if (bus.stage !== 4'd0 || bus.busy !== 1'b0) begin bad++; $display("FAIL ntt_idle stage=%0d busy=%b want 0 0", bus.stage, bus.busy); end
    for (int i = 0; i < NRD; i++) ref_seq[i] = rd_seq[i];
  endtask

  task automatic test_intt();
    logic [35:0] e0, e8;
    logic [17:0] t0, t8;
    e0 = {9'd3, 9'd2, 9'd1, 9'd0};     t0 = {9'd257, 9'd256};
    e8 = {9'd257, 9'd1, 9'd256, 9'd0}; t8 = {9'd1, 9'd1};
    clear_log();
    run(1'b1, 2000);
    total++; if (rd_seq[0] !== e0 || tf_seq[0] !== t0) begin bad++;
      $display("FAIL intt_s0 addr=%h tf=%h want %h %h", rd_seq[0], tf_seq[0], e0, t0); end
    total++; if (rd_seq[8*NGRP] !== e8 || tf_seq[8*NGRP] !== t8) begin bad++;
      $display("FAIL intt_s8 addr=%h tf=%h want %h %h", rd_seq[8*NGRP], tf_seq[8*NGRP], e8, t8); end
    total++; if (first_wr[0] != 14 || first_rd[1] != 142) begin bad++;
      $display("FAIL intt_latency wr0=%0d rd1=%0d want 14 142", first_wr[0], first_rd[1]); end
    total++; if (done_cyc != 1270 || done_n != 1) begin bad++; $display("FAIL intt_done cyc=%0d n=%0d want 1270 1", done_cyc, done_n); end
    total++; if (cov_bad() != 0 || raw_bad != 0 || seq_bad() != 0) begin bad++;
      $display("FAIL intt_scoreboard cov=%0d raw=%0d seq=%0d want 0 0 0", cov_bad(), raw_bad, seq_bad()); end
  endtask

  task automatic test_hold_stage3();
    int diff;
    clear_log();
    h0_from = 426; h0_len = 5;  // inside stage 3 READ (cycles 406..533)
    run(1'b0, 2000);
    diff = 0;
    for (int i = 0; i < NRD; i++) if (rd_seq[i] !== ref_seq[i]) diff++;
    total++; if (hold_bad != 0) begin bad++; $display("FAIL hold_quiet got %0d want 0", hold_bad); end
    total++; if (rd_n != NRD || diff != 0) begin bad++; $display("FAIL hold_sequence rd=%0d diff=%0d want %0d 0", rd_n, diff, NRD); end
    total++; if (done_cyc != 1221 || done_n != 1) begin bad++; $display("FAIL hold_done cyc=%0d n=%0d want 1221 1", done_cyc, done_n); end
    total++; if (cov_bad() != 0 || raw_bad != 0 || seq_bad() != 0) begin bad++;
      $display("FAIL hold_scoreboard cov=%0d raw=%0d seq=%0d want 0 0 0", cov_bad(), raw_bad, seq_bad()); end
  endtask

  task automatic test_start_hold_done_hold();
    clear_log();
    h0_from = 0; h0_len = 3;       // start+hold in IDLE, then two held READ cycles
    h1_from = 1218; h1_len = 2;    // hold across DONE and the following IDLE
    run(1'b0, 2000);
    total++; if (first_rd[0] != 3) begin bad++; $display("FAIL starthold_first_rd got %0d want 3", first_rd[0]); end
    total++; if (done_cyc != 1218 || done_n != 1) begin bad++; $display("FAIL donehold_pulse cyc=%0d n=%0d want 1218 1", done_cyc, done_n); end
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL donehold_idle busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    extra_start = 50;   // while busy: must be ignored
    run(1'b0, 2000);
    repeat (20) step();
    total++; if (done_n != 1 || done_cyc != 1216) begin bad++; $display("FAIL busy_start n=%0d cyc=%0d want 1 1216", done_n, done_cyc); end
    total++; if (rd_n != NRD || cov_bad() != 0) begin bad++; $display("FAIL busy_start_reads rd=%0d cov=%0d want %0d 0", rd_n, cov_bad(), NRD); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    rst_at = 600;
    cyc = 0; bus.mode = 1'b0; bus.start = 1'b1; bus.hold = 1'b0;
    while (cyc < 601) step();
    total++; if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.wr_valid !== 1'b0) begin bad++;
      $display("FAIL rstmid_quiet busy=%b rd=%b wr=%b want 0 0 0", bus.busy, bus.rd_valid, bus.wr_valid); end
    while (cyc < 1400) step();
    total++; if (done_n != 0) begin bad++; $display("FAIL rstmid_no_done got %0d want 0", done_n); end
    clear_log();
    run(1'b0, 2000);
    total++; if (done_cyc != 1216 || done_n != 1) begin bad++; $display("FAIL rstmid_restart cyc=%0d n=%0d want 1216 1", done_cyc, done_n); end
    total++; if (cov_bad() != 0 || raw_bad != 0 || seq_bad() != 0) begin bad++;
      $display("FAIL rstmid_scoreboard cov=%0d raw=%0d seq=%0d want 0 0 0", cov_bad(), raw_bad, seq_bad()); end
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.hold = 1'b0;
    test_reset();
    test_ntt();
    test_intt();
    test_hold_stage3();
    test_start_hold_done_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
